// File: rtl/hex_display_ctrl.sv
// rtl/hex_display_ctrl.sv - four-digit hex pager with debounced page key and timed auto-paging
module hex_display_ctrl #(
    parameter int PRESCALE = 50000000,
    parameter int DEBOUNCE = 500000
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        wrEn,
    input  logic [31:0] wrData,
    input  logic        keyIn,
    input  logic        autoPage,
    input  logic        blankIn,
    output logic [15:0] nibbleOut,
    output logic        pageOut,
    output logic        blankOut,
    output logic        updatedOut
);

    localparam int PW = $clog2(PRESCALE);
    localparam int DW = $clog2(DEBOUNCE);
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE - 1);

    logic [31:0]   r_shadow;
    logic          r_page;
    logic          r_updated;
    logic          r_blank;
    logic          r_sync1;
    logic          r_sync2;
    logic          r_key_acc;
    logic [DW-1:0] r_deb_cnt;
    logic [PW-1:0] r_pre_cnt;

    logic w_key_differs;
    logic w_deb_done;
    logic w_press;
    logic w_tick;
    logic w_toggle;

    // The accepted level flips on the same edge the debounce count completes,
    // so a press is reported on that edge rather than one edge later.
    assign w_key_differs = (r_sync2 != r_key_acc);
    assign w_deb_done    = w_key_differs && (r_deb_cnt == DEB_LAST);
    assign w_press       = w_deb_done && r_key_acc;
    assign w_tick        = autoPage && (r_pre_cnt == PRE_LAST);
    assign w_toggle      = w_press || w_tick;

    // Digits come straight from registered state; wrData never reaches the outputs combinationally.
    assign nibbleOut  = r_page ? r_shadow[31:16] : r_shadow[15:0];
    assign pageOut    = r_page;
    assign blankOut   = r_blank;
    assign updatedOut = r_updated;

    // Two-flop synchronizer for the asynchronous pushbutton; idles high (released).
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= keyIn;
            r_sync2 <= r_sync1;
        end
    end

    // Debouncer: count consecutive cycles the synchronized level disagrees with the accepted one.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_deb_cnt <= '0;
            r_key_acc <= 1'b1;
        end else if (!w_key_differs) begin
            r_deb_cnt <= '0;
        end else if (w_deb_done) begin
            r_deb_cnt <= '0;
            r_key_acc <= r_sync2;
        end else begin
            r_deb_cnt <= r_deb_cnt + DW'(1);
        end
    end

    // Auto-page prescaler: runs only while enabled and restarts on every key press.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_pre_cnt <= '0;
        end else if (!autoPage || w_press || w_tick) begin
            r_pre_cnt <= '0;
        end else begin
            r_pre_cnt <= r_pre_cnt + PW'(1);
        end
    end

    // Page flips once per cycle whether the cause is a press, a tick, or both together.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_page <= 1'b0;
        end else if (w_toggle) begin
            r_page <= ~r_page;
        end
    end

    // Shadow capture plus the write-acknowledge pulse that follows it.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_shadow  <= '0;
            r_updated <= 1'b0;
        end else begin
            if (wrEn) begin
                r_shadow <= wrData;
            end
            r_updated <= wrEn;
        end
    end

    // Blank request is only delayed one cycle; it never touches display state.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_blank <= 1'b0;
        end else begin
            r_blank <= blankIn;
        end
    end

endmodule

// File: tb/tb_hex_display_ctrl.sv
// tb/tb_hex_display_ctrl.sv - self-checking bench for hex_display_ctrl
module tb_hex_display_ctrl;

    localparam int PRE = 8;
    localparam int DEB = 4;

    logic        clk      = 1'b0;
    logic        resetN   = 1'b0;
    logic        wrEn     = 1'b0;
    logic [31:0] wrData   = 32'h0;
    logic        keyIn    = 1'b1;
    logic        autoPage = 1'b0;
    logic        blankIn  = 1'b0;
    logic [15:0] nibbleOut;
    logic        pageOut;
    logic        blankOut;
    logic        updatedOut;

    int   n_cmp = 0;
    int   n_err = 0;
    logic exp_page = 1'b0;

    // Reference model state
    logic [31:0] m_shadow;
    logic        m_page;
    logic        m_upd;
    logic        m_blank;
    logic        m_acc;
    int          m_run;
    int          m_pre;
    logic        m_pipe[$];

    always #5 clk = ~clk;

    hex_display_ctrl #(
        .PRESCALE(PRE),
        .DEBOUNCE(DEB)
    ) dut (
        .clk       (clk),
        .resetN    (resetN),
        .wrEn      (wrEn),
        .wrData    (wrData),
        .keyIn     (keyIn),
        .autoPage  (autoPage),
        .blankIn   (blankIn),
        .nibbleOut (nibbleOut),
        .pageOut   (pageOut),
        .blankOut  (blankOut),
        .updatedOut(updatedOut)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_shadow = 32'h0;
        m_page   = 1'b0;
        m_upd    = 1'b0;
        m_blank  = 1'b0;
        m_acc    = 1'b1;
        m_run    = 0;
        m_pre    = 0;
        m_pipe   = '{1'b1, 1'b1};
    endtask

    // Advances the model by one clock using the inputs currently driven.
    // A level is accepted after it has been seen, two cycles late, on DEB consecutive edges.
    task automatic model_step();
        logic seen;
        logic press;
        logic tick;
        press = 1'b0;
        tick  = 1'b0;
        seen  = m_pipe.pop_front();
        m_pipe.push_back(keyIn);
        if (seen != m_acc) begin
            m_run++;
            if (m_run == DEB) begin
                press = (m_acc == 1'b1);
                m_acc = seen;
                m_run = 0;
            end
        end else begin
            m_run = 0;
        end
        if (autoPage) begin
            m_pre++;
            if (m_pre == PRE) begin
                tick  = 1'b1;
                m_pre = 0;
            end
        end else begin
            m_pre = 0;
        end
        if (press) m_pre = 0;
        if (press || tick) m_page = ~m_page;
        if (wrEn) m_shadow = wrData;
        m_upd   = wrEn;
        m_blank = blankIn;
    endtask

    task automatic test_reset();
        resetN = 1'b0; wrEn = 1'b1; wrData = 32'hFFFF_FFFF; blankIn = 1'b1; keyIn = 1'b0; autoPage = 1'b1;
        #1;
        n_cmp++;
        if ({nibbleOut, pageOut, blankOut, updatedOut} !== 19'h0) begin
            n_err++; $display("FAIL reset_initial: got %h want 0", {nibbleOut, pageOut, blankOut, updatedOut});
        end
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++;
            if ({nibbleOut, pageOut, blankOut, updatedOut} !== 19'h0) begin
                n_err++; $display("FAIL reset_held: got %h want 0", {nibbleOut, pageOut, blankOut, updatedOut});
            end
        end
        wrEn = 1'b0; blankIn = 1'b0; keyIn = 1'b1; autoPage = 1'b0;
        @(negedge clk);
        resetN = 1'b1;
        step();
        n_cmp++;
        if ({nibbleOut, pageOut, blankOut, updatedOut} !== 19'h0) begin
            n_err++; $display("FAIL reset_release: got %h want 0", {nibbleOut, pageOut, blankOut, updatedOut});
        end
        exp_page = 1'b0;
    endtask

    task automatic test_write();
        wrEn = 1'b1; wrData = 32'hDEAD_BEEF;
        step();
        n_cmp++;
        if ({nibbleOut, pageOut, updatedOut} !== {16'hBEEF, 1'b0, 1'b1}) begin
            n_err++; $display("FAIL write_capture: got %h/%b/%b want beef/0/1", nibbleOut, pageOut, updatedOut);
        end
        wrEn = 1'b0; wrData = $urandom;
        for (int i = 0; i < 2; i++) begin
            step();
            n_cmp++;
            if ({nibbleOut, updatedOut} !== {16'hBEEF, 1'b0}) begin
                n_err++; $display("FAIL write_hold: got %h/%b want beef/0", nibbleOut, updatedOut);
            end
        end
    endtask

    task automatic test_key_press();
        logic [15:0] want_nib;
        keyIn = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            step();
            want_nib = (k >= 6) ? 16'hDEAD : 16'hBEEF;
            n_cmp++;
            if ({pageOut, nibbleOut} !== {(k >= 6), want_nib}) begin
                n_err++; $display("FAIL key_press edge %0d: got %b/%h want %b/%h", k, pageOut, nibbleOut, (k >= 6), want_nib);
            end
        end
        keyIn = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step();
            n_cmp++;
            if ({pageOut, nibbleOut} !== {1'b1, 16'hDEAD}) begin
                n_err++; $display("FAIL key_release edge %0d: got %b/%h want 1/dead", k, pageOut, nibbleOut);
            end
        end
        exp_page = 1'b1;
    endtask

    task automatic test_bounce();
        logic [18:0] pat;
        pat = 19'b1111111111110001000;
        for (int k = 0; k < 19; k++) begin
            keyIn = pat[k];
            step();
            n_cmp++;
            if (pageOut !== exp_page) begin
                n_err++; $display("FAIL bounce edge %0d: got %b want %b", k, pageOut, exp_page);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        for (int i = 1; i <= 3; i++) begin
            d = 32'h1111_1111 * i;
            wrEn = 1'b1; wrData = d;
            step();
            n_cmp++;
            if ({updatedOut, nibbleOut} !== {1'b1, (exp_page ? d[31:16] : d[15:0])}) begin
                n_err++; $display("FAIL back_to_back %0d: got %b/%h want 1/%h", i, updatedOut, nibbleOut, (exp_page ? d[31:16] : d[15:0]));
            end
        end
        wrEn = 1'b0;
        step();
        n_cmp++;
        if (updatedOut !== 1'b0) begin
            n_err++; $display("FAIL back_to_back_end: got %b want 0", updatedOut);
        end
    endtask

    task automatic test_auto_page();
        autoPage = 1'b1;
        for (int k = 1; k <= 28; k++) begin
            wrEn = (k == 8); wrData = 32'hCAFE_F00D;
            step();
            if (k % PRE == 0) exp_page = ~exp_page;
            n_cmp++;
            if (pageOut !== exp_page) begin
                n_err++; $display("FAIL auto_page edge %0d: got %b want %b", k, pageOut, exp_page);
            end
            if (k == 8) begin
                n_cmp++;
                if ({updatedOut, nibbleOut} !== {1'b1, (exp_page ? 16'hCAFE : 16'hF00D)}) begin
                    n_err++; $display("FAIL write_with_toggle: got %b/%h want 1/%h", updatedOut, nibbleOut, (exp_page ? 16'hCAFE : 16'hF00D));
                end
            end
        end
        wrEn = 1'b0;
        autoPage = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            step();
            n_cmp++;
            if (pageOut !== exp_page) begin
                n_err++; $display("FAIL auto_off edge %0d: got %b want %b", k, pageOut, exp_page);
            end
        end
        autoPage = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            if (k == 8) exp_page = ~exp_page;
            n_cmp++;
            if (pageOut !== exp_page) begin
                n_err++; $display("FAIL auto_restart edge %0d: got %b want %b", k, pageOut, exp_page);
            end
        end
        autoPage = 1'b0;
    endtask

    task automatic test_press_at_tick();
        autoPage = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            keyIn = (k >= 3 && k <= 10) ? 1'b0 : 1'b1;
            if (k == 17) autoPage = 1'b0;
            step();
            if (k == 8 || k == 16) exp_page = ~exp_page;
            n_cmp++;
            if (pageOut !== exp_page) begin
                n_err++; $display("FAIL press_at_tick edge %0d: got %b want %b", k, pageOut, exp_page);
            end
        end
        autoPage = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            keyIn = (k <= 8) ? 1'b0 : 1'b1;
            step();
            if (k == 6 || k == 14) exp_page = ~exp_page;
            n_cmp++;
            if (pageOut !== exp_page) begin
                n_err++; $display("FAIL press_restarts_prescale edge %0d: got %b want %b", k, pageOut, exp_page);
            end
        end
        autoPage = 1'b0;
        keyIn = 1'b1;
        repeat (10) step();
    endtask

    task automatic test_blank();
        logic [15:0] nib_before;
        nib_before = exp_page ? 16'hCAFE : 16'hF00D;
        blankIn = 1'b1;
        step();
        n_cmp++;
        if ({blankOut, pageOut, nibbleOut} !== {1'b1, exp_page, nib_before}) begin
            n_err++; $display("FAIL blank_on: got %b/%b/%h want 1/%b/%h", blankOut, pageOut, nibbleOut, exp_page, nib_before);
        end
        blankIn = 1'b0;
        step();
        n_cmp++;
        if ({blankOut, nibbleOut} !== {1'b0, nib_before}) begin
            n_err++; $display("FAIL blank_off: got %b/%h want 0/%h", blankOut, nibbleOut, nib_before);
        end
    endtask

    task automatic test_async_reset();
        wrEn = 1'b1; wrData = 32'h1234_5678;
        step();
        n_cmp++;
        if ({pageOut, nibbleOut} !== {1'b1, 16'h1234}) begin
            n_err++; $display("FAIL pre_reset_state: got %b/%h want 1/1234", pageOut, nibbleOut);
        end
        keyIn = 1'b0; blankIn = 1'b1;
        repeat (3) step();
        #2;
        resetN = 1'b0;
        #1;
        n_cmp++;
        if ({nibbleOut, pageOut, blankOut, updatedOut} !== 19'h0) begin
            n_err++; $display("FAIL async_reset: got %h want 0", {nibbleOut, pageOut, blankOut, updatedOut});
        end
        keyIn = 1'b1; wrEn = 1'b0; blankIn = 1'b0;
        @(negedge clk);
        resetN = 1'b1;
        exp_page = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            step();
            n_cmp++;
            if ({pageOut, nibbleOut} !== 17'h0) begin
                n_err++; $display("FAIL pending_press_lost edge %0d: got %b/%h want 0/0000", k, pageOut, nibbleOut);
            end
        end
        keyIn = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            step();
            n_cmp++;
            if (pageOut !== (k >= 6)) begin
                n_err++; $display("FAIL cold_start_press edge %0d: got %b want %b", k, pageOut, (k >= 6));
            end
        end
        keyIn = 1'b1;
        repeat (10) step();
    endtask

    task automatic test_random();
        int hold;
        logic [15:0] want_nib;
        resetN = 1'b0; keyIn = 1'b1; autoPage = 1'b0; wrEn = 1'b0; blankIn = 1'b0;
        model_reset();
        @(negedge clk);
        resetN = 1'b1;
        hold = 3;
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            wrEn    = ($urandom_range(0, 3) == 0);
            wrData  = $urandom;
            blankIn = $urandom_range(0, 1);
            if ($urandom_range(0, 39) == 0) autoPage = ~autoPage;
            if (hold == 0) begin
                keyIn = ~keyIn;
                hold  = $urandom_range(1, 8);
            end else begin
                hold--;
            end
            model_step();
            step();
            want_nib = m_page ? m_shadow[31:16] : m_shadow[15:0];
            n_cmp++;
            if ({nibbleOut, pageOut, updatedOut, blankOut} !== {want_nib, m_page, m_upd, m_blank}) begin
                n_err++;
                $display("FAIL random cycle %0d: got %h/%b/%b/%b want %h/%b/%b/%b", i,
                         nibbleOut, pageOut, updatedOut, blankOut, want_nib, m_page, m_upd, m_blank);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_key_press();
        test_bounce();
        test_back_to_back();
        test_auto_page();
        test_press_at_tick();
        test_blank();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/hex_display_ctrl.md
HEX_DISPLAY_CTRL -- requirements
Module: hex_display_ctrl

Interface
REQ-001 SHALL have parameter PRESCALE, default 50000000, auto-page period in clk cycles (1 s at 50 MHz); legal range >= 2.
REQ-002 SHALL have parameter DEBOUNCE, default 500000, cycles keyIn must be stable before acceptance (10 ms at 50 MHz); legal range >= 2.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port resetN  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port wrEn  input  1  write strobe; captures wrData on the edge where it is high.
REQ-006 SHALL have port wrData  input  32  value to display.
REQ-007 SHALL have port keyIn  input  1  raw DE1 pushbutton, active-low, asynchronous to clk.
REQ-008 SHALL have port autoPage  input  1  enables timed page alternation.
REQ-009 SHALL have port blankIn  input  1  request to blank all digits.
REQ-010 SHALL have port nibbleOut  output  16  four hex digits, [15:12]=HEX3 .. [3:0]=HEX0, one per downstream seven-segment decoder.
REQ-011 SHALL have port pageOut  output  1  0 = low half shown, 1 = high half shown.
REQ-012 SHALL have port blankOut  output  1  downstream forces segments to 7'b1111111 when high.
REQ-013 SHALL have port updatedOut  output  1  one-cycle pulse after a write is captured.

Function
REQ-014 SHALL hold a 32-bit shadow register loaded from wrData on each edge with wrEn=1; otherwise shadow holds.
REQ-015 SHALL drive nibbleOut = shadow[15:0] when page=0, shadow[31:16] when page=1, decoded from registers only (no combinational path from wrData); visible one edge after capture.
REQ-016 SHALL assert updatedOut for the cycle after each capturing edge; back-to-back wrEn keeps it high continuously.
REQ-017 SHALL pass keyIn through a two-flop synchronizer before any other use.
REQ-018 SHALL debounce: counter clears whenever synchronized level differs from accepted level, else increments; when it reaches DEBOUNCE-1 with the level still differing, accepted level takes the synchronized value and the counter clears.
REQ-019 SHALL generate a press event only on accepted-level transition 1->0; release (0->1) generates nothing.
REQ-020 SHALL run a prescaler 0..PRESCALE-1 while autoPage=1; at PRESCALE-1 it wraps to 0 and issues a tick; while autoPage=0 it is held at 0 and issues no tick.
REQ-021 SHALL toggle page on a press event or a tick; both in the same cycle toggle page exactly once.
REQ-022 SHALL clear the prescaler to 0 on every press event, so the next auto toggle is a full PRESCALE cycles later.
REQ-023 SHALL allow wrEn and a page toggle in the same cycle; both take effect on that edge.
REQ-024 SHALL register blankIn into blankOut with one-cycle latency; blanking does not affect shadow, page, or counters.
REQ-025 SHALL size counters as $clog2 of their parameter; no counter may overflow or wrap other than as specified.

Reset
REQ-026 SHALL, while resetN=0, immediately force: shadow=0, nibbleOut=16'h0000, page/pageOut=0, prescaler=0, debounce counter=0, synchronizer flops=1, accepted key level=1, updatedOut=0, blankOut=0.
REQ-027 SHALL discard any in-progress debounce or prescale count on reset; first edge after resetN rises behaves as from a cold start.

Verification (PRESCALE=8, DEBOUNCE=4)
REQ-028 SHALL cover: wrEn=1 one cycle with wrData=32'hDEADBEEF -> next edge nibbleOut=16'hBEEF, updatedOut=1 for exactly one cycle, pageOut=0.
REQ-029 SHALL cover: after REQ-028, keyIn low 10 cycles then high -> pageOut=1 and nibbleOut=16'hDEAD exactly 6 edges after keyIn falls (2 sync + 4 debounce); release produces no further toggle.
REQ-030 SHALL cover: keyIn low for 3 cycles then high -> pageOut unchanged; counter restarts on bounce.
REQ-031 SHALL cover: autoPage=1, no key -> pageOut toggles every 8 cycles; autoPage=0 mid-count -> no toggles and prescaler reads 0.
REQ-032 SHALL cover: press event forced on the same edge as prescaler terminal count -> single toggle, prescaler=0, next tick 8 cycles later.
REQ-033 SHALL cover: resetN pulsed low asynchronously mid-debounce with shadow=32'h12345678, page=1 -> all outputs reach REQ-026 values before next clk edge; pending press lost.
